// File: rtl/tdes_pkg.sv
// Shared types and constants for the triple-DES session sequencer slice.
package tdes_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEY2,
    ST_DATA,
    ST_RUN,
    ST_ERROR
  } tdes_state_e;

  localparam logic ED_ENCRYPT = 1'b0;
  localparam logic ED_DECRYPT = 1'b1;

  localparam int unsigned TIMEOUT_CYC_DEFAULT = 64;
  localparam int unsigned CNT_W_DEFAULT       = 16;

endpackage

// File: rtl/tdes_timeout_timer.sv
// Clear/enable cycle counter that stops at TIMEOUT_CYC-1 and flags terminal count.
module tdes_timeout_timer #(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic clk_i,
  input  logic n_rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [W-1:0] TC = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && (count_q != TC)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == TC);

endmodule

// File: rtl/tdes_session_sequencer.sv
// Drives key loads, core starts and output loads for one I2C triple-DES session,
// with a one-deep pending word latch, block counting, core timeout and stop abort.
module tdes_session_sequencer
  import tdes_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT,
  parameter int unsigned CNT_W       = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             i2c_stop,
  input  logic             i2c_rw,
  input  logic             word_ready,
  input  logic             des_next,
  output logic             key1_en,
  output logic             key2_en,
  output logic             des_ready,
  output logic             ed_sel,
  output logic             out_load,
  output logic             busy,
  output logic             pending,
  output logic [CNT_W-1:0] block_count,
  output logic             overrun_err,
  output logic             timeout_err
);

  tdes_state_e      state_q, state_d;
  logic             key1_en_q, key1_en_d;
  logic             key2_en_q, key2_en_d;
  logic             des_ready_q, des_ready_d;
  logic             out_load_q, out_load_d;
  logic             ed_sel_q, ed_sel_d;
  logic             busy_q, busy_d;
  logic             pending_q, pending_d;
  logic [CNT_W-1:0] block_count_q, block_count_d;
  logic             overrun_q, overrun_d;
  logic             timeout_q, timeout_d;
  logic             stop_req_q, stop_req_d;

  logic timer_clr;
  logic timer_en;
  logic timer_tc;

  assign timer_en = (state_q == ST_RUN);

  tdes_timeout_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk_i  (clk),
    .n_rst_i(n_rst),
    .clear_i(timer_clr),
    .en_i   (timer_en),
    .tc_o   (timer_tc)
  );

  always_comb begin
    state_d       = state_q;
    key1_en_d     = 1'b0;
    key2_en_d     = 1'b0;
    des_ready_d   = 1'b0;
    out_load_d    = 1'b0;
    ed_sel_d      = ed_sel_q;
    pending_d     = pending_q;
    block_count_d = block_count_q;
    overrun_d     = overrun_q;
    timeout_d     = timeout_q;
    stop_req_d    = stop_req_q;
    timer_clr     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (i2c_stop) begin
          pending_d = 1'b0;
        end else if (word_ready) begin
          key1_en_d     = 1'b1;
          ed_sel_d      = i2c_rw ? ED_DECRYPT : ED_ENCRYPT;
          block_count_d = '0;
          pending_d     = 1'b0;
          overrun_d     = 1'b0;
          timeout_d     = 1'b0;
          state_d       = ST_KEY2;
        end
      end

      ST_KEY2: begin
        if (i2c_stop) begin
          pending_d = 1'b0;
          state_d   = ST_IDLE;
        end else if (word_ready) begin
          key2_en_d = 1'b1;
          state_d   = ST_DATA;
        end
      end

      ST_DATA: begin
        if (i2c_stop) begin
          pending_d = 1'b0;
          state_d   = ST_IDLE;
        end else if (word_ready || pending_q) begin
          des_ready_d = 1'b1;
          pending_d   = 1'b0;
          timer_clr   = 1'b1;
          state_d     = ST_RUN;
        end
      end

      ST_RUN: begin
        if (i2c_stop) begin
          stop_req_d = 1'b1;
        end
        // A stop in the same cycle swallows the word; otherwise words queue or overrun.
        if (word_ready && !i2c_stop) begin
          if (pending_q) begin
            overrun_d = 1'b1;
          end else begin
            pending_d = 1'b1;
          end
        end
        if (des_next) begin
          out_load_d    = 1'b1;
          block_count_d = (&block_count_q) ? block_count_q : block_count_q + CNT_W'(1);
          if (stop_req_q || i2c_stop) begin
            pending_d  = 1'b0;
            stop_req_d = 1'b0;
            state_d    = ST_IDLE;
          end else begin
            state_d = ST_DATA;
          end
        end else if (timer_tc) begin
          timeout_d  = 1'b1;
          stop_req_d = 1'b0;
          state_d    = ST_ERROR;
        end
      end

      ST_ERROR: begin
        if (i2c_stop) begin
          pending_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= ST_IDLE;
      key1_en_q     <= 1'b0;
      key2_en_q     <= 1'b0;
      des_ready_q   <= 1'b0;
      out_load_q    <= 1'b0;
      ed_sel_q      <= ED_ENCRYPT;
      busy_q        <= 1'b0;
      pending_q     <= 1'b0;
      block_count_q <= '0;
      overrun_q     <= 1'b0;
      timeout_q     <= 1'b0;
      stop_req_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      key1_en_q     <= key1_en_d;
      key2_en_q     <= key2_en_d;
      des_ready_q   <= des_ready_d;
      out_load_q    <= out_load_d;
      ed_sel_q      <= ed_sel_d;
      busy_q        <= busy_d;
      pending_q     <= pending_d;
      block_count_q <= block_count_d;
      overrun_q     <= overrun_d;
      timeout_q     <= timeout_d;
      stop_req_q    <= stop_req_d;
    end
  end

  assign key1_en     = key1_en_q;
  assign key2_en     = key2_en_q;
  assign des_ready   = des_ready_q;
  assign out_load    = out_load_q;
  assign ed_sel      = ed_sel_q;
  assign busy        = busy_q;
  assign pending     = pending_q;
  assign block_count = block_count_q;
  assign overrun_err = overrun_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_tdes_session_sequencer.sv
// Bench for tdes_session_sequencer: out_load events are checked against a queue
// of expected block counts pushed whenever des_next is driven.
module tb_tdes_session_sequencer;

  logic clk;
  logic n_rst;
  logic i2c_stop, i2c_rw, word_ready, des_next;
  logic key1_en, key2_en, des_ready, ed_sel, out_load, busy, pending;
  logic overrun_err, timeout_err;
  logic [15:0] block_count;

  logic t_stop, t_word, t_next;
  logic t_key1_en, t_key2_en, t_des_ready, t_ed_sel, t_out_load, t_busy, t_pending;
  logic t_overrun_err, t_timeout_err;
  logic [15:0] t_block_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt_key1 = 0;
  int cnt_key2 = 0;
  int cnt_desr = 0;
  logic [15:0] mdl_cnt;
  logic [15:0] exp_q[$];
  logic [15:0] exp_bc;

  tdes_session_sequencer #(.TIMEOUT_CYC(64), .CNT_W(16)) dut (
    .clk(clk), .n_rst(n_rst), .i2c_stop(i2c_stop), .i2c_rw(i2c_rw),
    .word_ready(word_ready), .des_next(des_next), .key1_en(key1_en),
    .key2_en(key2_en), .des_ready(des_ready), .ed_sel(ed_sel),
    .out_load(out_load), .busy(busy), .pending(pending),
    .block_count(block_count), .overrun_err(overrun_err), .timeout_err(timeout_err)
  );

  tdes_session_sequencer #(.TIMEOUT_CYC(8), .CNT_W(16)) dut_to (
    .clk(clk), .n_rst(n_rst), .i2c_stop(t_stop), .i2c_rw(1'b0),
    .word_ready(t_word), .des_next(t_next), .key1_en(t_key1_en),
    .key2_en(t_key2_en), .des_ready(t_des_ready), .ed_sel(t_ed_sel),
    .out_load(t_out_load), .busy(t_busy), .pending(t_pending),
    .block_count(t_block_count), .overrun_err(t_overrun_err), .timeout_err(t_timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counting and out_load scoreboard, sampled on the inactive edge.
  always @(negedge clk) begin
    if (n_rst) begin
      if (key1_en)   cnt_key1++;
      if (key2_en)   cnt_key2++;
      if (des_ready) cnt_desr++;
      if (out_load) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL out_load_unexpected: got out_load with block_count=%0d, required no out_load", block_count);
        end else begin
          exp_bc = exp_q.pop_front();
          if (block_count !== exp_bc) begin
            n_fail++;
            $display("FAIL sb_block_count: got %0d, required %0d", block_count, exp_bc);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic word();
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
  endtask

  task automatic stop();
    i2c_stop = 1'b1;
    tick();
    i2c_stop = 1'b0;
  endtask

  task automatic complete();
    des_next = 1'b1;
    mdl_cnt  = (mdl_cnt == 16'hFFFF) ? mdl_cnt : mdl_cnt + 16'd1;
    exp_q.push_back(mdl_cnt);
    tick();
    des_next = 1'b0;
  endtask

  task automatic start_session(input logic rw);
    i2c_rw  = rw;
    mdl_cnt = '0;
    word();
    tick();
    word();
    tick();
  endtask

  task automatic t_pulse_word();
    t_word = 1'b1;
    tick();
    t_word = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    i2c_stop = 0; i2c_rw = 0; word_ready = 0; des_next = 0;
    t_stop = 0; t_word = 0; t_next = 0;
    mdl_cnt = '0;
    repeat (2) tick();
    n_checks++;
    if ({key1_en, key2_en, des_ready, ed_sel, out_load, busy, pending, overrun_err, timeout_err, block_count} !== 25'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, required 0", {key1_en, key2_en, des_ready, ed_sel, out_load, busy, pending, overrun_err, timeout_err, block_count});
    end
    n_checks++;
    if ({t_busy, t_timeout_err, t_block_count} !== 18'd0) begin
      n_fail++;
      $display("FAIL reset_to_outputs: got %h, required 0", {t_busy, t_timeout_err, t_block_count});
    end
    n_rst = 1'b1;
    tick();
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b, required 0", busy); end
  endtask

  task automatic test_basic_encrypt();
    int k1, k2, dr;
    k1 = cnt_key1; k2 = cnt_key2; dr = cnt_desr;
    i2c_rw = 1'b0;
    mdl_cnt = '0;
    word();
    n_checks++;
    if (key1_en !== 1'b1) begin n_fail++; $display("FAIL basic_key1: got %b, required 1", key1_en); end
    n_checks++;
    if (busy !== 1'b1 || ed_sel !== 1'b0) begin n_fail++; $display("FAIL basic_busy_ed: got busy=%b ed=%b, required 1 0", busy, ed_sel); end
    tick();
    n_checks++;
    if (key1_en !== 1'b0) begin n_fail++; $display("FAIL basic_key1_width: got %b, required 0", key1_en); end
    word();
    n_checks++;
    if (key2_en !== 1'b1) begin n_fail++; $display("FAIL basic_key2: got %b, required 1", key2_en); end
    tick();
    word();
    n_checks++;
    if (des_ready !== 1'b1) begin n_fail++; $display("FAIL basic_des_ready: got %b, required 1", des_ready); end
    repeat (15) tick();
    complete();
    n_checks++;
    if (out_load !== 1'b1 || block_count !== 16'd1) begin
      n_fail++; $display("FAIL basic_out_load: got out_load=%b count=%0d, required 1 1", out_load, block_count);
    end
    tick();
    n_checks++;
    if (out_load !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL basic_after_load: got out_load=%b busy=%b, required 0 1", out_load, busy); end
    n_checks++;
    if (cnt_key1 - k1 != 1 || cnt_key2 - k2 != 1 || cnt_desr - dr != 1) begin
      n_fail++; $display("FAIL basic_pulse_counts: got %0d %0d %0d, required 1 1 1", cnt_key1 - k1, cnt_key2 - k2, cnt_desr - dr);
    end
    stop();
    n_checks++;
    if (busy !== 1'b0 || block_count !== 16'd1 || ed_sel !== 1'b0) begin
      n_fail++; $display("FAIL basic_idle_hold: got busy=%b count=%0d ed=%b, required 0 1 0", busy, block_count, ed_sel);
    end
  endtask

  task automatic test_back_to_back();
    start_session(1'b0);
    word();
    n_checks++;
    if (des_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_first_issue: got %b, required 1", des_ready); end
    tick(); tick();
    word();
    n_checks++;
    if (pending !== 1'b1 || des_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_pending_set: got pending=%b des_ready=%b, required 1 0", pending, des_ready); end
    repeat (3) tick();
    complete();
    n_checks++;
    if (out_load !== 1'b1 || des_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_load: got out_load=%b des_ready=%b, required 1 0", out_load, des_ready); end
    tick();
    n_checks++;
    if (des_ready !== 1'b1 || pending !== 1'b0) begin n_fail++; $display("FAIL b2b_second_issue: got des_ready=%b pending=%b, required 1 0", des_ready, pending); end
    repeat (5) tick();
    complete();
    n_checks++;
    if (block_count !== 16'd2) begin n_fail++; $display("FAIL b2b_count: got %0d, required 2", block_count); end
    tick();
    stop();
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_stop_idle: got %b, required 0", busy); end
  endtask

  task automatic test_overrun();
    int dr;
    start_session(1'b0);
    dr = cnt_desr;
    word();
    tick();
    word();
    tick();
    word();
    n_checks++;
    if (overrun_err !== 1'b1 || pending !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: got overrun=%b pending=%b, required 1 1", overrun_err, pending); end
    tick();
    complete();
    tick();
    n_checks++;
    if (des_ready !== 1'b1) begin n_fail++; $display("FAIL ovr_pending_issue: got %b, required 1", des_ready); end
    tick(); tick();
    complete();
    tick(); tick();
    n_checks++;
    if (cnt_desr - dr != 2 || block_count !== 16'd2 || pending !== 1'b0 || overrun_err !== 1'b1) begin
      n_fail++; $display("FAIL ovr_result: got issues=%0d count=%0d pending=%b overrun=%b, required 2 2 0 1", cnt_desr - dr, block_count, pending, overrun_err);
    end
    stop();
    i2c_rw = 1'b0;
    mdl_cnt = '0;
    word();
    n_checks++;
    if (overrun_err !== 1'b0 || block_count !== 16'd0) begin n_fail++; $display("FAIL ovr_clear_on_start: got overrun=%b count=%0d, required 0 0", overrun_err, block_count); end
    tick();
    stop();
  endtask

  task automatic test_timeout();
    t_pulse_word(); tick(); t_pulse_word(); tick(); t_pulse_word();
    n_checks++;
    if (t_des_ready !== 1'b1) begin n_fail++; $display("FAIL to_issue: got %b, required 1", t_des_ready); end
    repeat (7) tick();
    n_checks++;
    if (t_timeout_err !== 1'b0 || t_busy !== 1'b1) begin n_fail++; $display("FAIL to_early: got timeout=%b busy=%b, required 0 1", t_timeout_err, t_busy); end
    tick();
    n_checks++;
    if (t_timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_flag: got %b, required 1", t_timeout_err); end
    tick();
    t_pulse_word();
    n_checks++;
    if (t_key1_en !== 1'b0 || t_des_ready !== 1'b0 || t_busy !== 1'b1) begin
      n_fail++; $display("FAIL to_error_hold: got key1=%b des_ready=%b busy=%b, required 0 0 1", t_key1_en, t_des_ready, t_busy);
    end
    t_stop = 1'b1; tick(); t_stop = 1'b0;
    n_checks++;
    if (t_busy !== 1'b0 || t_timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_stop_exit: got busy=%b timeout=%b, required 0 1", t_busy, t_timeout_err); end
    tick();
    t_pulse_word();
    n_checks++;
    if (t_timeout_err !== 1'b0 || t_key1_en !== 1'b1) begin n_fail++; $display("FAIL to_new_session: got timeout=%b key1=%b, required 0 1", t_timeout_err, t_key1_en); end
    tick(); t_pulse_word(); tick(); t_pulse_word();
    repeat (7) tick();
    t_next = 1'b1; tick(); t_next = 1'b0;
    n_checks++;
    if (t_out_load !== 1'b1 || t_timeout_err !== 1'b0 || t_block_count !== 16'd1) begin
      n_fail++; $display("FAIL to_edge_des_next: got out_load=%b timeout=%b count=%0d, required 1 0 1", t_out_load, t_timeout_err, t_block_count);
    end
    tick();
    n_checks++;
    if (t_timeout_err !== 1'b0 || t_busy !== 1'b1) begin n_fail++; $display("FAIL to_edge_after: got timeout=%b busy=%b, required 0 1", t_timeout_err, t_busy); end
    t_stop = 1'b1; tick(); t_stop = 1'b0;
  endtask

  task automatic test_stop_mid_block();
    int dr;
    start_session(1'b0);
    word();
    tick();
    word();
    tick();
    stop();
    n_checks++;
    if (busy !== 1'b1 || pending !== 1'b1 || out_load !== 1'b0) begin
      n_fail++; $display("FAIL stop_run_hold: got busy=%b pending=%b out_load=%b, required 1 1 0", busy, pending, out_load);
    end
    tick();
    dr = cnt_desr;
    complete();
    n_checks++;
    if (out_load !== 1'b1 || busy !== 1'b0 || pending !== 1'b0) begin
      n_fail++; $display("FAIL stop_finish: got out_load=%b busy=%b pending=%b, required 1 0 0", out_load, busy, pending);
    end
    repeat (4) tick();
    n_checks++;
    if (cnt_desr != dr || busy !== 1'b0 || block_count !== 16'd1) begin
      n_fail++; $display("FAIL stop_no_issue: got issues=%0d busy=%b count=%0d, required 0 0 1", cnt_desr - dr, busy, block_count);
    end
  endtask

  task automatic test_async_reset();
    start_session(1'b1);
    n_checks++;
    if (ed_sel !== 1'b1) begin n_fail++; $display("FAIL ares_ed_sel: got %b, required 1", ed_sel); end
    word();
    tick();
    complete();
    tick();
    word();
    tick();
    word();
    n_checks++;
    if (pending !== 1'b1 || block_count !== 16'd1) begin n_fail++; $display("FAIL ares_pre: got pending=%b count=%0d, required 1 1", pending, block_count); end
    #3;
    n_rst = 1'b0;
    #1;
    n_checks++;
    if ({key1_en, key2_en, des_ready, ed_sel, out_load, busy, pending, overrun_err, timeout_err, block_count} !== 25'd0) begin
      n_fail++;
      $display("FAIL ares_outputs: got %h, required 0", {key1_en, key2_en, des_ready, ed_sel, out_load, busy, pending, overrun_err, timeout_err, block_count});
    end
    tick();
    n_rst = 1'b1;
    tick();
    i2c_rw = 1'b0;
    mdl_cnt = '0;
    word();
    n_checks++;
    if (key1_en !== 1'b1 || des_ready !== 1'b0) begin n_fail++; $display("FAIL ares_restart: got key1=%b des_ready=%b, required 1 0", key1_en, des_ready); end
    tick();
    stop();
  endtask

  initial begin
    test_reset();
    test_basic_encrypt();
    test_back_to_back();
    test_overrun();
    test_timeout();
    test_stop_mid_block();
    test_async_reset();
    repeat (2) tick();
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL sb_drain: got %0d outstanding out_load, required 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
